// File: rtl/omni_pkg.sv
// omni_pkg: shared types and constants for the omni stream merger.
//   arb_state_e          - arbiter FSM state encoding (IDLE / HOLD)
//   num_ports()          - slot count plus the loopback port
//   HDR_*                - header field positions shared with the dispatcher
package omni_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // Input port count: every top-k slot plus one loopback port at the top index.
  function automatic int num_ports(input int num_slots);
    return num_slots + 1;
  endfunction

  // Beat header layout, kept here so the dispatcher decodes the same bits.
  localparam int HDR_NEXT_BLK_ID_MSB = 31;
  localparam int HDR_NEXT_BLK_ID_LSB = 2;
  localparam int HDR_RST_BIT         = 0;

endpackage

// File: rtl/omni_skid_buf.sv
// omni_skid_buf: 2-entry output FIFO that decouples rx_TREADY from tx_TREADY.
//   clk, rst_n  - clock, async active-low reset
//   flush_i     - synchronous flush, drops held entries
//   push_i/data_i - write one entry (ignored when full)
//   pop_i       - drop head entry (ignored when empty)
//   data_o      - head entry
//   count_o     - occupancy 0..2
module omni_skid_buf #(
  parameter int WIDTH = 600
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [1:0][WIDTH-1:0] mem_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;
  logic                  push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q != 2'd2);
  assign pop_ok  = pop_i  && (cnt_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/omni_arbiter.sv
// omni_arbiter: round-robin merge of NUM_SLOTS+1 AXI-Stream inputs into one
// output, with bursts of up to MAX_BURST beats per grant.
//   clk, rst_n, soft_rst - clock, async active-low reset, sync flush
//   rx_TDATA/TVALID/TREADY - input ports; port NUM_SLOTS is loopback
//   tx_TDATA/TVALID/TREADY - merged output stream (2-entry buffered)
//   grant_id - currently/last granted port
//   beat_cnt - free-running count of tx handshakes (wraps)
module omni_arbiter
  import omni_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int WIDTH     = 600,
  parameter int MAX_BURST = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           soft_rst,
  input  logic [(NUM_SLOTS+1)*WIDTH-1:0] rx_TDATA,
  input  logic [NUM_SLOTS:0]             rx_TVALID,
  output logic [NUM_SLOTS:0]             rx_TREADY,
  output logic [WIDTH-1:0]               tx_TDATA,
  output logic                           tx_TVALID,
  input  logic                           tx_TREADY,
  output logic [$clog2(NUM_SLOTS+1)-1:0] grant_id,
  output logic [CNT_WIDTH-1:0]           beat_cnt
);

  localparam int NUM_PORTS = num_ports(NUM_SLOTS);
  localparam int GW        = $clog2(NUM_PORTS);
  localparam int BW        = $clog2(MAX_BURST + 1);

  logic [NUM_PORTS-1:0][WIDTH-1:0] rx_data;
  assign rx_data = rx_TDATA;

  arb_state_e     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d, rr_q, rr_d, pick_idx, grant_nxt;
  logic [BW-1:0]  burst_q, burst_d;
  logic [CNT_WIDTH-1:0] beat_q;
  logic           pick_vld, grant_vld, accept;
  logic [1:0]     buf_cnt;
  logic [WIDTH-1:0] buf_data;

  // First valid port at or after rr_q, scanning cyclically.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!pick_vld && rx_TVALID[(int'(rr_q) + k) % NUM_PORTS]) begin
        pick_vld = 1'b1;
        pick_idx = GW'((int'(rr_q) + k) % NUM_PORTS);
      end
    end
  end

  // Ready comes from registered state only (plus the flush gate), so
  // tx_TREADY never reaches rx_TREADY combinationally.
  always_comb begin
    rx_TREADY = '0;
    if (state_q == ST_HOLD && !soft_rst) rx_TREADY[grant_q] = (buf_cnt != 2'd2);
  end

  assign grant_vld = rx_TVALID[grant_q];
  assign accept    = grant_vld && rx_TREADY[grant_q];
  assign grant_nxt = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) burst_d = burst_q + 1'b1;
        // A source going idle releases the grant immediately so others aren't starved.
        if (!grant_vld || (accept && burst_q == BW'(MAX_BURST - 1))) begin
          state_d = ST_IDLE;
          rr_d    = grant_nxt;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else if (soft_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      if (tx_TVALID && tx_TREADY) beat_q <= beat_q + 1'b1;
    end
  end

  omni_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (soft_rst),
    .push_i  (accept),
    .data_i  (rx_data[grant_q]),
    .pop_i   (tx_TREADY),
    .data_o  (buf_data),
    .count_o (buf_cnt)
  );

  assign tx_TVALID = (buf_cnt != 2'd0);
  assign tx_TDATA  = buf_data;
  assign grant_id  = grant_q;
  assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_omni_arbiter.sv
// tb_omni_arbiter: directed test of omni_arbiter (3 ports, 16-bit beats,
// burst 4, 4-bit beat counter). Beat data = {port[3:0], seq[11:0]}.
module tb_omni_arbiter;
  localparam int NP = 3;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk, rst_n, soft_rst;
  logic [NP*W-1:0] rx_TDATA;
  logic [NP-1:0] rx_TVALID, rx_TREADY;
  logic [W-1:0]  tx_TDATA;
  logic          tx_TVALID, tx_TREADY;
  logic [1:0]    grant_id;
  logic [CW-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;
  int sent[NP];
  int rcvd[NP];
  int rem[NP];
  int txcount;
  logic [W-1:0] log_q[$];

  omni_arbiter #(.NUM_SLOTS(2), .WIDTH(W), .MAX_BURST(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
    .rx_TDATA(rx_TDATA), .rx_TVALID(rx_TVALID), .rx_TREADY(rx_TREADY),
    .tx_TDATA(tx_TDATA), .tx_TVALID(tx_TVALID), .tx_TREADY(tx_TREADY),
    .grant_id(grant_id), .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      rx_TVALID[p]       = (rem[p] > 0);
      rx_TDATA[p*W +: W] = {4'(p), 12'(sent[p])};
    end
  endtask

  // One clock: record handshakes seen before the edge, then update sources
  // and check each output beat against its port's expected sequence.
  task automatic tick();
    logic [NP-1:0] hs;
    logic          txhs;
    logic [W-1:0]  d;
    int            pt;
    #1;
    hs   = rx_TVALID & rx_TREADY;
    txhs = tx_TVALID & tx_TREADY & !soft_rst;
    d    = tx_TDATA;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++)
      if (hs[p]) begin
        sent[p]++;
        rem[p]--;
      end
    drive();
    if (txhs) begin
      txcount++;
      log_q.push_back(d);
      pt = int'(d[15:12]);
      if (pt < NP) begin
        chk("tx_order", 64'(d[11:0]), 64'(rcvd[pt]));
        rcvd[pt]++;
      end else begin
        chk("tx_port_range", 64'(pt), 64'(NP - 1));
      end
    end
  endtask

  task automatic resync();
    for (int p = 0; p < NP; p++) rcvd[p] = sent[p];
    txcount = 0;
    log_q.delete();
  endtask

  task automatic flush();
    for (int p = 0; p < NP; p++) rem[p] = 0;
    drive();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    resync();
  endtask

  initial begin
    int base;
    int guard;
    bit s15, s16;
    rst_n = 1'b0; soft_rst = 1'b0; tx_TREADY = 1'b1; txcount = 0;
    for (int p = 0; p < NP; p++) begin
      sent[p] = 0; rcvd[p] = 0; rem[p] = 1000;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    // Reset with all ports valid
    chk("rst_tvalid", tx_TVALID, 0);
    chk("rst_tdata", tx_TDATA, 0);
    chk("rst_tready", rx_TREADY, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_beat", beat_cnt, 0);
    rst_n = 1'b1;

    // Round robin, all valid, no backpressure
    tick();
    chk("rr_grant0", grant_id, 0);
    chk("rr_ready0", rx_TREADY, 3'b001);
    repeat (4) tick();
    chk("rr_idle_ready", rx_TREADY, 0);
    tick();
    chk("rr_grant1", grant_id, 1);
    repeat (5) tick();
    chk("rr_grant2", grant_id, 2);
    repeat (5) tick();
    chk("rr_grant0_again", grant_id, 0);
    repeat (6) tick();
    chk("rr_log_len", log_q.size() >= 16, 1);
    for (int i = 0; i < 16; i++)
      if (i < log_q.size())
        chk("rr_seq", log_q[i], {4'((i / 4) % 3), 12'((i / 12) * 4 + i % 4)});

    // Backpressure mid-burst
    flush();
    rem[0] = 1000; drive();
    tick();
    chk("bp_pre_valid", tx_TVALID, 0);
    base = sent[0];
    tick();
    chk("bp_latency_valid", tx_TVALID, 1);
    chk("bp_latency_data", tx_TDATA, {4'd0, 12'(base)});
    tx_TREADY = 1'b0;
    repeat (10) tick();
    chk("bp_buffered", 64'(sent[0] - rcvd[0]), 2);
    chk("bp_ready", rx_TREADY, 0);
    chk("bp_tvalid", tx_TVALID, 1);
    chk("bp_head", tx_TDATA, {4'd0, 12'(base)});
    chk("bp_beat_hold", beat_cnt, 0);
    tx_TREADY = 1'b1;
    repeat (6) tick();
    chk("bp_accepted", 64'(sent[0] - base), 6);
    rem[0] = 0; drive();
    repeat (6) tick();
    chk("bp_drained", 64'(rcvd[0]), 64'(sent[0]));
    chk("bp_empty", tx_TVALID, 0);

    // Early release of port 1, port 2 waiting, port 0 joins late
    flush();
    rem[1] = 2; rem[2] = 1000; drive();
    tick();
    chk("er_grant1", grant_id, 1);
    tick(); tick();
    rem[0] = 1000; drive();
    tick();
    chk("er_exit_idle", rx_TREADY, 0);
    tick();
    chk("er_grant2", grant_id, 2);
    chk("er_ready2", rx_TREADY, 3'b100);
    for (int p = 0; p < NP; p++) rem[p] = 0;
    drive();
    repeat (8) tick();
    chk("er_p1_beats", 64'(rcvd[1]), 64'(sent[1]));
    chk("er_p2_drain", 64'(rcvd[2]), 64'(sent[2]));

    // Soft reset with buffer full mid-burst
    flush();
    rem[1] = 1000; drive();
    tick();
    chk("sr_grant1", grant_id, 1);
    tick(); tick();
    tx_TREADY = 1'b0;
    tick();
    chk("sr_full_ready", rx_TREADY, 0);
    chk("sr_full_valid", tx_TVALID, 1);
    chk("sr_buffered", 64'(sent[1] - rcvd[1]), 2);
    chk("sr_beat_pre", beat_cnt, 1);
    soft_rst = 1'b1; tx_TREADY = 1'b1; rem[0] = 1000; rem[2] = 1000; drive();
    tick();
    soft_rst = 1'b0;
    chk("sr_tvalid", tx_TVALID, 0);
    chk("sr_beat", beat_cnt, 0);
    chk("sr_grant", grant_id, 0);
    resync();
    tick();
    chk("sr_next_grant", grant_id, 0);
    chk("sr_next_ready", rx_TREADY, 3'b001);
    soft_rst = 1'b1;
    #1;
    chk("sr_ready_gated", rx_TREADY, 0);
    tick();
    soft_rst = 1'b0;
    resync();

    // Beat counter wrap at 4 bits
    guard = 0; s15 = 1'b0; s16 = 1'b0;
    while (txcount < 17 && guard < 200) begin
      tick();
      guard++;
      if (txcount == 15 && !s15) begin s15 = 1'b1; chk("wrap_15", beat_cnt, 15); end
      if (txcount == 16 && !s16) begin s16 = 1'b1; chk("wrap_16", beat_cnt, 0); end
    end
    chk("wrap_done", 64'(txcount), 17);
    chk("wrap_17", beat_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
